// File: rtl/write_back.sv
// write_back: final pipeline stage. Retires execute results into the
// architectural register file, issues single-beat stores, and redirects
// fetch when an instruction writes the program-counter register.
//
// Ports
//   clock, reset_n          : sole clock; asynchronous active-low reset
//   is_valid / hold         : execute handshake (accepted when is_valid & !hold)
//   pc, adjustment_value,
//   destination_value,
//   upper_value             : execute results
//   destination_register    : target register index
//   flags                   : condition flags from execute
//   has_flushed             : bubble marker (no architectural effect)
//   is_writing_memory       : store marker
//   has_upper_value         : second result goes to destination_register+1
//   registers               : architectural register file (index 0 reads 0)
//   mem_address,
//   mem_writedata,
//   mem_write               : store request, held until mem_waitrequest=0
//   mem_waitrequest         : memory not yet accepting
//   next_pc                 : fetch address
//   flush_out               : one-cycle pulse after a PC-targeting retire
//
// state  | meaning
// ACCEPT | idle, hold=0, ready to retire an instruction
// UPPER  | writing the latched upper_value to destination_register+1
// STORE  | mem_write asserted, waiting for mem_waitrequest=0

module write_back #(
  parameter int NR    = 4,
  parameter int Flags = NR - 1,
  parameter int PC    = NR - 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 is_valid,
  output logic                 hold,
  input  logic [31:0]          pc,
  input  logic [31:0]          adjustment_value,
  input  logic [31:0]          destination_value,
  input  logic [31:0]          upper_value,
  input  logic [4:0]           destination_register,
  input  logic [3:0]           flags,
  input  logic                 has_flushed,
  input  logic                 is_writing_memory,
  input  logic                 has_upper_value,
  output logic [NR-1:0][31:0]  registers,
  output logic [31:0]          mem_address,
  output logic [31:0]          mem_writedata,
  output logic                 mem_write,
  input  logic                 mem_waitrequest,
  output logic [31:0]          next_pc,
  output logic                 flush_out
);

  typedef enum logic [1:0] {ACCEPT, UPPER, STORE} state_t;

  localparam logic [4:0] FLAGS_IDX = 5'(Flags);
  localparam logic [4:0] PC_IDX    = 5'(PC);

  state_t              state;
  logic [31:0]         upper_q;
  logic [5:0]          upper_idx;

  logic                accept;
  logic                retire;
  logic                dest_is_pc;
  logic [31:0]         new_pc;
  logic [NR-1:0][31:0] regs_d;

  assign accept     = is_valid && (state == ACCEPT);
  assign retire     = accept && !has_flushed;
  assign dest_is_pc = (destination_register == PC_IDX);
  assign new_pc     = dest_is_pc ? destination_value : (pc + 32'd4);

  // Next register-file contents. Only indices 1..NR-1 are ever matched, so
  // writes to index 0 or to out-of-range indices fall away naturally.
  always_comb begin
    regs_d = registers;
    if (retire) begin
      for (int i = 1; i < NR; i++) begin
        if (!is_writing_memory && destination_register == 5'(i)) begin
          regs_d[i] = destination_value;
        end
      end
      // An explicit write of the flags register supersedes the flags input.
      if (is_writing_memory || destination_register != FLAGS_IDX) begin
        regs_d[Flags][3:0] = flags;
      end
      regs_d[PC] = new_pc;
    end else if (state == UPPER) begin
      for (int i = 1; i < NR; i++) begin
        if (upper_idx == 6'(i)) begin
          regs_d[i] = upper_q;
        end
      end
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ACCEPT;
      hold          <= 1'b0;
      registers     <= '0;
      next_pc       <= '0;
      flush_out     <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
      upper_q       <= '0;
      upper_idx     <= '0;
    end else begin
      registers <= regs_d;
      flush_out <= 1'b0;
      case (state)
        ACCEPT: begin
          if (retire) begin
            next_pc   <= new_pc;
            flush_out <= dest_is_pc;
            // A store ignores any upper result.
            if (is_writing_memory) begin
              mem_address   <= destination_value;
              mem_writedata <= adjustment_value;
              mem_write     <= 1'b1;
              hold          <= 1'b1;
              state         <= STORE;
            end else if (has_upper_value) begin
              upper_q   <= upper_value;
              // Widened so index 31 does not wrap back onto index 0.
              upper_idx <= {1'b0, destination_register} + 6'd1;
              hold      <= 1'b1;
              state     <= UPPER;
            end
          end
        end
        UPPER: begin
          hold  <= 1'b0;
          state <= ACCEPT;
        end
        STORE: begin
          if (!mem_waitrequest) begin
            mem_write <= 1'b0;
            hold      <= 1'b0;
            state     <= ACCEPT;
          end
        end
        default: begin
          mem_write <= 1'b0;
          hold      <= 1'b0;
          state     <= ACCEPT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_write_back.sv
module tb_write_back;

  localparam int NR = 4;
  localparam int FL = NR - 1;
  localparam int PCI = NR - 2;

  logic                clock = 1'b0;
  logic                reset_n;
  logic                is_valid;
  logic                hold;
  logic [31:0]         pc, adjustment_value, destination_value, upper_value;
  logic [4:0]          destination_register;
  logic [3:0]          flags;
  logic                has_flushed, is_writing_memory, has_upper_value;
  logic [NR-1:0][31:0] registers;
  logic [31:0]         mem_address, mem_writedata;
  logic                mem_write;
  logic                mem_waitrequest;
  logic [31:0]         next_pc;
  logic                flush_out;

  write_back dut (
    .clock(clock), .reset_n(reset_n), .is_valid(is_valid), .hold(hold),
    .pc(pc), .adjustment_value(adjustment_value),
    .destination_value(destination_value), .upper_value(upper_value),
    .destination_register(destination_register), .flags(flags),
    .has_flushed(has_flushed), .is_writing_memory(is_writing_memory),
    .has_upper_value(has_upper_value), .registers(registers),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_write(mem_write), .mem_waitrequest(mem_waitrequest),
    .next_pc(next_pc), .flush_out(flush_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc, adj, dval, uval;
    logic [4:0]  dest;
    logic [3:0]  flags;
    bit          bubble, store, upper;
  } instr_t;

  typedef struct {
    instr_t      ins;
    int          waits;
    logic [31:0] r1, r2, r3, npc;
    bit          fl;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [NR];
  logic [31:0] m_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic instr_t mk(input logic [4:0] d, input logic [31:0] dv,
                                input logic [31:0] uv, input logic [31:0] av,
                                input logic [3:0] f, input logic [31:0] p,
                                input bit b, input bit s, input bit u);
    instr_t t;
    t.dest = d; t.dval = dv; t.uval = uv; t.adj = av; t.flags = f; t.pc = p;
    t.bubble = b; t.store = s; t.upper = u;
    return t;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_pc = '0;
  endtask

  // Architectural effect of one retired instruction, end state after any
  // upper write. Returns whether a fetch redirect is expected.
  task automatic model_apply(input instr_t t, output bit exp_flush);
    int d;
    exp_flush = 0;
    if (t.bubble) return;
    d = int'(t.dest);
    exp_flush = (d == PCI);
    m_pc = exp_flush ? t.dval : t.pc + 32'd4;
    if (t.store) begin
      m_regs[FL][3:0] = t.flags;
    end else if (d == FL) begin
      m_regs[FL] = t.dval;
    end else begin
      if (d > 0 && d < NR) m_regs[d] = t.dval;
      m_regs[FL][3:0] = t.flags;
    end
    m_regs[PCI] = m_pc;
    if (!t.store && t.upper && d + 1 < NR) m_regs[d + 1] = t.uval;
    m_regs[0] = '0;
  endtask

  task automatic check_state(input string tag);
    for (int i = 0; i < NR; i++)
      chk($sformatf("%s_reg%0d", tag, i), registers[i], m_regs[i]);
    chk({tag, "_next_pc"}, next_pc, m_pc);
  endtask

  task automatic drive(input instr_t t);
    pc = t.pc; adjustment_value = t.adj; destination_value = t.dval;
    upper_value = t.uval; destination_register = t.dest; flags = t.flags;
    has_flushed = t.bubble; is_writing_memory = t.store; has_upper_value = t.upper;
  endtask

  // Issue one instruction, keep is_valid and fields stable while hold=1,
  // then compare the whole architectural state against the model.
  task automatic run(input instr_t t, input int waits, output bit flush_seen);
    bit ef;
    int n;
    @(negedge clock);
    drive(t);
    is_valid = 1'b1;
    mem_waitrequest = 1'b1;
    @(posedge clock); #1;
    model_apply(t, ef);
    flush_seen = flush_out;
    chk("flush_out", flush_out, 32'(ef));
    if (!t.bubble && t.store) begin
      n = 0;
      while (mem_write === 1'b1 && n < 64) begin
        chk("store_hold", 32'(hold), 32'd1);
        chk("store_addr", mem_address, t.dval);
        chk("store_data", mem_writedata, t.adj);
        @(negedge clock);
        mem_waitrequest = (n < waits);
        n++;
        @(posedge clock); #1;
        chk("store_flush_low", 32'(flush_out), 32'd0);
      end
      chk("store_cycles", 32'(n), 32'(waits + 1));
    end else if (!t.bubble && t.upper) begin
      chk("upper_hold", 32'(hold), 32'd1);
      chk("upper_mem_write", 32'(mem_write), 32'd0);
      @(posedge clock); #1;
      chk("upper_flush_low", 32'(flush_out), 32'd0);
    end else begin
      chk("plain_hold", 32'(hold), 32'd0);
      is_valid = 1'b0;
      @(posedge clock); #1;
      chk("plain_flush_low", 32'(flush_out), 32'd0);
    end
    is_valid = 1'b0;
    chk("hold_after", 32'(hold), 32'd0);
    chk("mem_write_after", 32'(mem_write), 32'd0);
    check_state("state");
  endtask

  vec_t vecs [9];

  initial begin
    bit fs;
    instr_t t;
    int w;

    reset_n = 1'b0; is_valid = 1'b0; mem_waitrequest = 1'b0;
    drive(mk(5'd0, 0, 0, 0, 4'h0, 0, 0, 0, 0));
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("reset_hold", 32'(hold), 32'd0);
    chk("reset_mem_write", 32'(mem_write), 32'd0);
    chk("reset_flush", 32'(flush_out), 32'd0);
    check_state("reset");
    @(negedge clock);
    reset_n = 1'b1;

    //                dest   dval          uval         adj      fl    pc      bub st up
    vecs[0] = '{mk(5'd1,  32'h12345678, 0,           0,       4'hA, 32'h100,  0, 0, 0), 0,
                32'h12345678, 32'h104, 32'h0000000A, 32'h104, 0};
    vecs[1] = '{mk(5'd2,  32'h2000,     0,           0,       4'h3, 32'h104,  0, 0, 0), 0,
                32'h12345678, 32'h2000, 32'h3, 32'h2000, 1};
    vecs[2] = '{mk(5'd1,  32'h40,       0,           32'hDEAD, 4'h5, 32'h2000, 0, 1, 0), 3,
                32'h12345678, 32'h2004, 32'h5, 32'h2004, 0};
    vecs[3] = '{mk(5'd1,  32'h5,        32'h7,       0,       4'h0, 32'h2004, 0, 0, 1), 0,
                32'h5, 32'h7, 32'h0, 32'h2008, 0};
    vecs[4] = '{mk(5'd3,  32'h55AA0000, 32'h99,      0,       4'hF, 32'h2008, 0, 0, 1), 0,
                32'h5, 32'h200C, 32'h55AA0000, 32'h200C, 0};
    vecs[5] = '{mk(5'd1,  32'hFFFF,     0,           0,       4'h1, 32'h9000, 1, 0, 0), 0,
                32'h5, 32'h200C, 32'h55AA0000, 32'h200C, 0};
    vecs[6] = '{mk(5'd0,  32'h9,        0,           0,       4'h6, 32'h200C, 0, 0, 0), 0,
                32'h5, 32'h2010, 32'h55AA0006, 32'h2010, 0};
    vecs[7] = '{mk(5'd20, 32'h77,       0,           0,       4'h9, 32'h2010, 0, 0, 0), 0,
                32'h5, 32'h2014, 32'h55AA0009, 32'h2014, 0};
    vecs[8] = '{mk(5'd1,  32'h80,       32'h1234,    32'hBEEF, 4'h2, 32'h2014, 0, 1, 1), 0,
                32'h5, 32'h2018, 32'h55AA0002, 32'h2018, 0};

    for (int i = 0; i < 9; i++) begin
      run(vecs[i].ins, vecs[i].waits, fs);
      chk($sformatf("vec%0d_r0", i), registers[0], 32'h0);
      chk($sformatf("vec%0d_r1", i), registers[1], vecs[i].r1);
      chk($sformatf("vec%0d_r2", i), registers[2], vecs[i].r2);
      chk($sformatf("vec%0d_r3", i), registers[3], vecs[i].r3);
      chk($sformatf("vec%0d_npc", i), next_pc, vecs[i].npc);
      chk($sformatf("vec%0d_flush", i), 32'(fs), 32'(vecs[i].fl));
    end

    // Upper write lands one edge after the primary write.
    @(negedge clock);
    drive(mk(5'd1, 32'hA1, 32'hB2, 0, 4'h0, 32'h3000, 0, 0, 1));
    is_valid = 1'b1;
    @(posedge clock); #1;
    chk("upper_primary_r1", registers[1], 32'hA1);
    chk("upper_primary_r2", registers[2], 32'h3004);
    @(posedge clock); #1;
    is_valid = 1'b0;
    chk("upper_second_r2", registers[2], 32'hB2);
    chk("upper_second_hold", 32'(hold), 32'd0);
    model_apply(mk(5'd1, 32'hA1, 32'hB2, 0, 4'h0, 32'h3000, 0, 0, 1), fs);
    check_state("upper_seq");

    // Reset asserted in the middle of a stalled store.
    @(negedge clock);
    drive(mk(5'd1, 32'h300, 0, 32'h55, 4'h7, 32'h4000, 0, 1, 0));
    is_valid = 1'b1;
    mem_waitrequest = 1'b1;
    @(posedge clock); #1;
    is_valid = 1'b0;
    chk("midstore_mem_write", 32'(mem_write), 32'd1);
    @(posedge clock); #3;
    reset_n = 1'b0;
    #1;
    chk("async_mem_write", 32'(mem_write), 32'd0);
    chk("async_hold", 32'(hold), 32'd0);
    chk("async_flush", 32'(flush_out), 32'd0);
    chk("async_addr", mem_address, 32'h0);
    chk("async_data", mem_writedata, 32'h0);
    model_reset();
    check_state("async");
    @(negedge clock);
    reset_n = 1'b1;
    t = mk(5'd1, 32'hABC, 0, 0, 4'h4, 32'h500, 0, 0, 0);
    drive(t);
    is_valid = 1'b1;
    @(posedge clock); #1;
    is_valid = 1'b0;
    model_apply(t, fs);
    chk("post_reset_hold", 32'(hold), 32'd0);
    chk("post_reset_mem_write", 32'(mem_write), 32'd0);
    check_state("post_reset");

    // Randomised instructions against the model.
    for (int k = 0; k < 200; k++) begin
      t.pc = {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
      t.dval = $urandom; t.uval = $urandom; t.adj = $urandom;
      t.flags = 4'($urandom_range(0, 15));
      t.bubble = ($urandom_range(0, 9) == 0);
      t.store = ($urandom_range(0, 4) == 0);
      t.upper = ($urandom_range(0, 3) == 0);
      if (t.store)
        t.dest = ($urandom_range(0, 1) == 0) ? 5'd1 : 5'($urandom_range(4, 31));
      else if ($urandom_range(0, 7) == 0)
        t.dest = 5'($urandom_range(0, 31));
      else
        t.dest = 5'($urandom_range(0, 5));
      w = $urandom_range(0, 3);
      run(t, w, fs);
      if ($urandom_range(0, 7) == 0) begin
        // Idle cycle with junk fields: is_valid=0 must have no effect.
        @(negedge clock);
        drive(mk(5'($urandom_range(0, 3)), $urandom, $urandom, $urandom, 4'hF, $urandom, 0, 1, 1));
        @(posedge clock); #1;
        check_state("idle");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/write_back.md
WRITE_BACK -- requirements
Module: write_back

Interface
REQ-001 Parameter: NR, 4, number of architectural registers; index 0 reads as zero.
REQ-002 Parameter: Flags, NR-1, index of the flags register.
REQ-003 Parameter: PC, NR-2, index of the program-counter register.
REQ-004 Port: clock  in  1  sole clock; all state changes on its rising edge.
REQ-005 Port: reset_n  in  1  reset, asynchronous and active-low.
REQ-006 Port: is_valid  in  1  execute stage presents an instruction this cycle.
REQ-007 Port: hold  out  1  stage cannot accept an instruction this cycle.
REQ-008 Port: pc, adjustment_value, destination_value, upper_value  in  32 each  execute results (execute-to-write fields).
REQ-009 Port: destination_register  in  5  target register index.
REQ-010 Port: flags  in  4  condition flags produced by execute.
REQ-011 Port: has_flushed, is_writing_memory, has_upper_value  in  1 each  bubble marker, store marker, two-result marker.
REQ-012 Port: registers  out  NR x 32  architectural register file contents.
REQ-013 Port: mem_address, mem_writedata  out  32 each  store address and data.
REQ-014 Port: mem_write  out  1  store request; mem_waitrequest  in  1  memory not yet accepting.
REQ-015 Port: next_pc  out  32  fetch address; flush_out  out  1  one-cycle pulse: fetch must discard in-flight work.

Function
REQ-016 Acceptance: instruction accepted on a rising edge where is_valid=1 and hold=0; no other edge has side effects from input fields.
REQ-017 Bubble: accepted instruction with has_flushed=1 causes no register, memory, next_pc or flush_out change.
REQ-018 FSM states: ACCEPT, UPPER, STORE; reset state ACCEPT; hold=0 only in ACCEPT.
REQ-019 Plain instruction (has_flushed=0, is_writing_memory=0, has_upper_value=0): one edge after acceptance registers[destination_register] = destination_value; Flags[3:0] = flags, Flags[31:4] preserved; registers[PC] = next_pc; stay in ACCEPT.
REQ-020 Writes to index 0 or index >= NR discarded; registers[0] always 0.
REQ-021 destination_register == Flags: destination_value written whole, flags input ignored that instruction.
REQ-022 next_pc: updated on every non-bubble retire; equals destination_value when destination_register == PC, else pc + 4 (mod 2^32).
REQ-023 destination_register == PC: flush_out = 1 for exactly the cycle after the retire edge, else 0.
REQ-024 has_upper_value=1: primary write as REQ-019 on acceptance edge, FSM to UPPER; next edge writes upper_value (latched at acceptance) to index destination_register+1 under REQ-020, returns to ACCEPT; total hold = 1 cycle.
REQ-025 is_writing_memory=1: no register write except flags and registers[PC]; latch mem_address = destination_value, mem_writedata = adjustment_value; mem_write = 1 from next cycle; FSM to STORE.
REQ-026 STORE: mem_write held with stable address/data until an edge where mem_waitrequest=0; that edge drops mem_write and returns to ACCEPT; no time-out.
REQ-027 is_writing_memory and has_upper_value both set: store takes precedence, upper_value ignored.
REQ-028 Input fields ignored while hold=1; execute holds them stable.

Reset
REQ-029 reset_n low at any time, including mid UPPER or STORE: immediately FSM=ACCEPT, hold=0, mem_write=0, flush_out=0, registers all 0, next_pc=0, mem_address=0, mem_writedata=0.
REQ-030 Operation resumes on first rising edge after reset_n returns high; pending store or upper write abandoned.

Verification
REQ-031 Plain: dest=1, value=0x12345678, flags=0xA, pc=0x100 -> next edge registers[1]=0x12345678, registers[3]=0x0000000A, next_pc=0x104, hold stays 0.
REQ-032 Branch: dest=2, value=0x2000 -> next_pc=0x2000, registers[2]=0x2000, flush_out high exactly one cycle.
REQ-033 Store with mem_waitrequest high 3 cycles: dest_value=0x40, adj=0xDEAD -> mem_write=1, address 0x40, data 0xDEAD for 4 cycles, hold=1 throughout, then ACCEPT; no GPR change.
REQ-034 Upper: dest=1, value=5, upper=7, has_upper_value=1 -> registers[1]=5, one edge later registers[2]=7; hold=1 for one cycle; dest=3 upper write discarded (index 4 >= NR).
REQ-035 Bubble and zero: has_flushed=1 with dest=1 -> nothing changes; dest=0 value=9 -> registers[0] stays 0, next_pc advances.
REQ-036 Reset mid-store: reset_n low during STORE -> mem_write and hold drop asynchronously, all registers 0; after release new instruction accepted on first edge.
